psum_collector: RTL and testbench



---
 rtl/psum_collector.sv | 183 ++++++++++++++++++
 tb/tb_psum_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// psum_collector: drain-side receiver for one PE-array column.
// After a Start pulse it waits Latency cycles, captures Num_out words from
// the bottom PE into a small FIFO, and presents them first-word-fall-through
// over a valid/ready handshake. Dropped captures raise a sticky Overflow.

module psum_collector #(
    parameter int Data_width = 32,
    parameter int Depth      = 16,
    parameter int Cnt_width  = 8
) (
    input  logic                      iClk,
    input  logic                      iRest_n,
    input  logic                      Start,
    input  logic [Cnt_width-1:0]      Latency,
    input  logic [Cnt_width-1:0]      Num_out,
    input  logic [Data_width-1:0]     Psum_f_pe,
    input  logic                      Out_ready,
    output logic                      Out_valid,
    output logic [Data_width-1:0]     Out_data,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Overflow,
    output logic [$clog2(Depth):0]    Count
);

    localparam int Ptr_width = $clog2(Depth);
    localparam logic [Ptr_width:0] Full_count = (Ptr_width + 1)'(Depth);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [Cnt_width-1:0]   wait_cnt;
    logic [Cnt_width-1:0]   cap_cnt;
    logic                   job_start;
    logic                   capture;

    logic [Data_width-1:0]  mem [Depth];
    logic [Ptr_width-1:0]   wr_ptr;
    logic [Ptr_width-1:0]   rd_ptr;
    logic [Ptr_width-1:0]   rd_ptr_next;
    logic [Ptr_width:0]     count_next;
    logic [Ptr_width:0]     after_read;
    logic                   rd;
    logic                   wr;

    // State register: reset always returns the job FSM to IDLE
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: Start is only honoured in IDLE, so a running job cannot be restarted
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (Num_out == '0) begin
                        next_state = S_DONE;
                    end else if (Latency == '0) begin
                        next_state = S_CAPTURE;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt <= Cnt_width'(1)) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (cap_cnt <= Cnt_width'(1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        job_start = (state == S_IDLE) && Start;
        capture   = (state == S_CAPTURE);
        Busy      = (state != S_IDLE);
        Done      = (state == S_DONE);
    end

    // Job counters: loaded on an accepted Start, counted down while waiting / capturing
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            wait_cnt <= '0;
            cap_cnt  <= '0;
        end else if (job_start) begin
            wait_cnt <= Latency;
            cap_cnt  <= Num_out;
        end else begin
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                cap_cnt <= cap_cnt - 1'b1;
            end
        end
    end

    // FIFO control: a full FIFO still accepts a write when a read frees a slot in the same cycle
    always_comb begin
        rd          = Out_valid && Out_ready;
        wr          = capture && ((Count != Full_count) || rd);
        rd_ptr_next = rd ? rd_ptr + 1'b1 : rd_ptr;
        after_read  = Count - (Ptr_width + 1)'(rd);
        count_next  = Count;
        if (wr && !rd) begin
            count_next = Count + 1'b1;
        end else if (!wr && rd) begin
            count_next = Count - 1'b1;
        end
    end

    assign Out_valid = (Count != '0);

    // FIFO storage: contents are not reset, only pointers and occupancy are
    always_ff @(posedge iClk) begin
        if (wr) begin
            mem[wr_ptr] <= Psum_f_pe;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since Depth is a power of two
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            Count  <= count_next;
        end
    end

    // Registered head word: load the new head, or the incoming word when it becomes the head, else hold
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            Out_data <= '0;
        end else if (after_read == '0) begin
            if (wr) begin
                Out_data <= Psum_f_pe;
            end
        end else begin
            Out_data <= mem[rd_ptr_next];
        end
    end

    // Sticky drop flag, cleared only when a new job is accepted
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            Overflow <= 1'b0;
        end else if (job_start) begin
            Overflow <= 1'b0;
        end else if (capture && !wr) begin
            Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: randomized and directed stimulus for psum_collector,
// checked every cycle against a job-window / queue reference model.

module tb_psum_collector;

    localparam int Data_width = 32;
    localparam int Depth      = 16;
    localparam int Cnt_width  = 8;

    logic                    iClk = 1'b0;
    logic                    iRest_n;
    logic                    Start;
    logic [Cnt_width-1:0]    Latency;
    logic [Cnt_width-1:0]    Num_out;
    logic [Data_width-1:0]   Psum_f_pe;
    logic                    Out_ready;
    logic                    Out_valid;
    logic [Data_width-1:0]   Out_data;
    logic                    Busy;
    logic                    Done;
    logic                    Overflow;
    logic [$clog2(Depth):0]  Count;

    int checks   = 0;
    int failures = 0;

    // Reference model state: current job window, FIFO contents as a queue
    logic [31:0] model_q[$];
    bit          m_busy;
    int          m_ks;
    int          m_lat;
    int          m_num;
    int          m_end;
    bit          m_ovf;
    logic [31:0] m_last;
    int          edge_no;

    psum_collector #(
        .Data_width (Data_width),
        .Depth      (Depth),
        .Cnt_width  (Cnt_width)
    ) dut (
        .iClk       (iClk),
        .iRest_n    (iRest_n),
        .Start      (Start),
        .Latency    (Latency),
        .Num_out    (Num_out),
        .Psum_f_pe  (Psum_f_pe),
        .Out_ready  (Out_ready),
        .Out_valid  (Out_valid),
        .Out_data   (Out_data),
        .Busy       (Busy),
        .Done       (Done),
        .Overflow   (Overflow),
        .Count      (Count)
    );

    // Free-running clock
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h edge=%0d", tag, observed, expected, edge_no);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        m_busy = 1'b0;
        m_ks   = 0;
        m_lat  = 0;
        m_num  = 0;
        m_end  = 0;
        m_ovf  = 1'b0;
        m_last = '0;
    endtask

    // One rising edge of the reference: job window arithmetic plus queue behaviour
    task automatic modelEdge(input bit st, input int lat, input int num, input logic [31:0] psum, input bit rdy);
        bit cap;
        bit rd;
        bit wok;
        if (st && !m_busy) begin
            m_ks  = edge_no;
            m_lat = lat;
            m_num = num;
            m_end = (num == 0) ? edge_no + 1 : edge_no + lat + num + 1;
            m_ovf = 1'b0;
        end
        m_busy = (edge_no >= m_ks) && (edge_no < m_end);
        cap = (m_num > 0) && (edge_no >= m_ks + m_lat + 1) && (edge_no <= m_ks + m_lat + m_num);
        rd  = rdy && (model_q.size() > 0);
        wok = cap && ((model_q.size() < Depth) || rd);
        if (cap && !wok) m_ovf = 1'b1;
        if (rd) void'(model_q.pop_front());
        if (wok) model_q.push_back(psum);
        if (model_q.size() > 0) m_last = model_q[0];
    endtask

    task automatic checkAll(input string ctx);
        bit exp_done;
        exp_done = m_busy && (edge_no == m_end - 1);
        checkOutput({ctx, " busy"},  32'(Busy),      32'(m_busy));
        checkOutput({ctx, " done"},  32'(Done),      32'(exp_done));
        checkOutput({ctx, " ovf"},   32'(Overflow),  32'(m_ovf));
        checkOutput({ctx, " count"}, 32'(Count),     32'(model_q.size()));
        checkOutput({ctx, " valid"}, 32'(Out_valid), 32'(model_q.size() > 0));
        checkOutput({ctx, " data"},  Out_data,       m_last);
    endtask

    task automatic applyStimulus(input bit st, input int lat, input int num, input logic [31:0] psum, input bit rdy);
        Start     = st;
        Latency   = Cnt_width'(lat);
        Num_out   = Cnt_width'(num);
        Psum_f_pe = psum;
        Out_ready = rdy;
        @(posedge iClk);
        edge_no++;
        modelEdge(st, lat, num, psum, rdy);
        #1;
        checkAll("cyc");
        Start = 1'b0;
    endtask

    task automatic midReset();
        iRest_n = 1'b0;
        #1;
        modelReset();
        checkAll("rst");
        @(posedge iClk);
        @(posedge iClk);
        @(negedge iClk);
        iRest_n = 1'b1;
    endtask

    initial begin
        int rdy_pct;
        iRest_n   = 1'b0;
        Start     = 1'b0;
        Latency   = '0;
        Num_out   = '0;
        Psum_f_pe = '0;
        Out_ready = 1'b0;
        edge_no   = 0;
        modelReset();

        // Reset held for two cycles, then released with no Start
        repeat (2) @(posedge iClk);
        #1;
        checkAll("reset");
        @(negedge iClk);
        iRest_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, $urandom, 1);

        // Basic capture: Latency=2, Num_out=2
        applyStimulus(1, 2, 2, $urandom, 1);
        applyStimulus(0, 0, 0, $urandom, 1);
        applyStimulus(0, 0, 0, $urandom, 1);
        applyStimulus(0, 0, 0, 32'h3CBB7324, 1);
        checkOutput("basic first", Out_data, 32'h3CBB7324);
        applyStimulus(0, 0, 0, 32'h3DC73B12, 1);
        checkOutput("basic second", Out_data, 32'h3DC73B12);
        checkOutput("basic done", 32'(Done), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, $urandom, 1);

        // Zero cases
        applyStimulus(1, 5, 0, $urandom, 1);
        checkOutput("zero num done", 32'(Done), 32'd1);
        applyStimulus(0, 0, 0, $urandom, 1);
        applyStimulus(1, 0, 1, $urandom, 1);
        applyStimulus(0, 0, 0, 32'hCAFE0001, 1);
        checkOutput("zero lat data", Out_data, 32'hCAFE0001);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, $urandom, 1);

        // Backpressure and overflow: ramp 1..20 into a 16-deep FIFO
        applyStimulus(1, 1, 20, $urandom, 0);
        applyStimulus(0, 0, 0, $urandom, 0);
        for (int i = 1; i <= 20; i++) applyStimulus(0, 0, 0, 32'(i), 0);
        checkOutput("ovf count", 32'(Count), 32'd16);
        checkOutput("ovf flag", 32'(Overflow), 32'd1);
        checkOutput("ovf head", Out_data, 32'd1);
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 0, $urandom, 1);
        checkOutput("ovf sticky", 32'(Overflow), 32'd1);

        // Full FIFO with simultaneous read and write across pointer wrap
        applyStimulus(1, 0, 16, $urandom, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 32'(100 + i), 0);
        applyStimulus(0, 0, 0, $urandom, 0);
        applyStimulus(1, 0, 10, $urandom, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 32'(200 + i), 1);
        checkOutput("full rw count", 32'(Count), 32'd16);
        checkOutput("full rw ovf", 32'(Overflow), 32'd0);
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 0, $urandom, 1);

        // Start pulses during WAIT and CAPTURE are ignored
        applyStimulus(1, 3, 4, $urandom, 1);
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1 + i, $urandom, 1);
        applyStimulus(0, 0, 0, $urandom, 1);

        // Reset in the middle of a capture, then a normal job
        applyStimulus(1, 0, 10, $urandom, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, $urandom, 0);
        midReset();
        applyStimulus(1, 1, 3, $urandom, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, $urandom, 1);

        // Randomized traffic with varying downstream readiness
        rdy_pct = 80;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 399) == 0) begin
                midReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 6), $urandom_range(0, 22),
                              $urandom, $urandom_range(1, 100) <= rdy_pct);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
